// File: rtl/huffman_code_seq_if.sv
// ============================================================================
// Module      : huffman_code_seq_if
// Description : Bus between the Huffman count stage and the code sequencer.
//               master drives the six symbol counts with a one-cycle
//               CNT_valid strobe and observes busy/code_valid/HC/M.
//               slave (the sequencer) receives the counts and publishes the
//               codewords and masks.
// Signals     : CNT_valid        count strobe (master -> slave)
//               CNT1..CNT6       per-symbol counts, CNT_W bits
//               busy             sequence in progress (slave -> master)
//               code_valid       one-cycle strobe, HC/M valid
//               HC1..HC6         right-aligned codewords, CODE_W bits
//               M1..M6           codeword masks, CODE_W bits
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface huffman_code_seq_if #(
  parameter int CNT_W  = 8,
  parameter int CODE_W = 8
) ();
  logic              CNT_valid;
  logic [CNT_W-1:0]  CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
  logic              busy;
  logic              code_valid;
  logic [CODE_W-1:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [CODE_W-1:0] M1, M2, M3, M4, M5, M6;

  modport master (
    output CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    input  busy, code_valid,
    input  HC1, HC2, HC3, HC4, HC5, HC6,
    input  M1, M2, M3, M4, M5, M6
  );

  modport slave (
    input  CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    output busy, code_valid,
    output HC1, HC2, HC3, HC4, HC5, HC6,
    output M1, M2, M3, M4, M5, M6
  );
endinterface

`default_nettype wire

// File: rtl/huffman_code_seq.sv
// ============================================================================
// Module      : huffman_code_seq
// Description : Builds Huffman codewords and masks for six symbols from
//               their counts. A CNT_valid strobe in IDLE captures the counts
//               into six weight slots, five MERGE cycles combine the two
//               lightest active slots each, and DONE publishes HC1..HC6 /
//               M1..M6 with a one-cycle code_valid strobe.
// Ports       : clk    rising-edge clock
//               reset  asynchronous, active-low reset
//               bus    huffman_code_seq_if.slave (counts in, codes out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module huffman_code_seq #(
  parameter int CNT_W  = 8,
  parameter int CODE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  huffman_code_seq_if.slave     bus
);

  // Three extra bits hold the sum of all six counts without wrapping.
  localparam int                c_WGT_W = CNT_W + 3;
  localparam int                c_NSYM  = 6;
  localparam logic [CODE_W-1:0] c_ONE   = CODE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MERGE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_step;
  logic                r_busy;
  logic                r_code_valid;
  logic [c_WGT_W-1:0]  r_weight [c_NSYM];
  logic                r_active [c_NSYM];
  logic [2:0]          r_group  [c_NSYM];
  logic [CODE_W-1:0]   r_code   [c_NSYM];
  logic [2:0]          r_len    [c_NSYM];
  logic [CODE_W-1:0]   r_hc     [c_NSYM];
  logic [CODE_W-1:0]   r_m      [c_NSYM];

  logic [CNT_W-1:0]    w_cnt [c_NSYM];
  logic [2:0]          w_a, w_b, w_s, w_d;
  logic                w_found_a, w_found_b;
  logic [c_WGT_W-1:0]  w_best_a, w_best_b;

  assign w_cnt[0] = bus.CNT1;
  assign w_cnt[1] = bus.CNT2;
  assign w_cnt[2] = bus.CNT3;
  assign w_cnt[3] = bus.CNT4;
  assign w_cnt[4] = bus.CNT5;
  assign w_cnt[5] = bus.CNT6;

  // Lightest active slot; '<=' lets a later (higher) index win a tie.
  always_comb begin
    w_a       = 3'd0;
    w_found_a = 1'b0;
    w_best_a  = '0;
    for (int i = 0; i < c_NSYM; i++) begin
      if (r_active[i] && (!w_found_a || r_weight[i] <= w_best_a)) begin
        w_a       = 3'(i);
        w_best_a  = r_weight[i];
        w_found_a = 1'b1;
      end
    end
  end

  // Second lightest: same rule with slot a excluded.
  always_comb begin
    w_b       = 3'd0;
    w_found_b = 1'b0;
    w_best_b  = '0;
    for (int i = 0; i < c_NSYM; i++) begin
      if (r_active[i] && (3'(i) != w_a) &&
          (!w_found_b || r_weight[i] <= w_best_b)) begin
        w_b       = 3'(i);
        w_best_b  = r_weight[i];
        w_found_b = 1'b1;
      end
    end
  end

  // The lower-numbered slot of the pair survives and carries the sum.
  assign w_s = (w_a < w_b) ? w_a : w_b;
  assign w_d = (w_a < w_b) ? w_b : w_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_step       <= 3'd0;
      r_busy       <= 1'b0;
      r_code_valid <= 1'b0;
      for (int k = 0; k < c_NSYM; k++) begin
        r_weight[k] <= '0;
        r_active[k] <= 1'b0;
        r_group[k]  <= 3'd0;
        r_code[k]   <= '0;
        r_len[k]    <= 3'd0;
        r_hc[k]     <= '0;
        r_m[k]      <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_code_valid <= 1'b0;
          if (bus.CNT_valid) begin
            for (int k = 0; k < c_NSYM; k++) begin
              r_weight[k] <= {3'b000, w_cnt[k]};
              r_active[k] <= 1'b1;
              r_group[k]  <= 3'(k);
              r_code[k]   <= '0;
              r_len[k]    <= 3'd0;
            end
            r_step  <= 3'd1;
            r_busy  <= 1'b1;
            r_state <= S_MERGE;
          end
        end

        S_MERGE: begin
          // Codes grow from the leaf upward: each merge prepends one bit
          // above the bits already assigned (1 for group a, 0 for group b).
          for (int k = 0; k < c_NSYM; k++) begin
            if (r_group[k] == w_a) begin
              r_code[k]  <= r_code[k] | (c_ONE << r_len[k]);
              r_len[k]   <= r_len[k] + 3'd1;
              r_group[k] <= w_s;
            end else if (r_group[k] == w_b) begin
              r_len[k]   <= r_len[k] + 3'd1;
              r_group[k] <= w_s;
            end
          end
          r_weight[w_s] <= r_weight[w_a] + r_weight[w_b];
          r_active[w_d] <= 1'b0;
          if (r_step == 3'd5) begin
            r_state <= S_DONE;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end

        S_DONE: begin
          for (int k = 0; k < c_NSYM; k++) begin
            r_hc[k] <= r_code[k];
            r_m[k]  <= (c_ONE << r_len[k]) - c_ONE;
          end
          r_code_valid <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.code_valid = r_code_valid;
  assign bus.HC1 = r_hc[0];
  assign bus.HC2 = r_hc[1];
  assign bus.HC3 = r_hc[2];
  assign bus.HC4 = r_hc[3];
  assign bus.HC5 = r_hc[4];
  assign bus.HC6 = r_hc[5];
  assign bus.M1  = r_m[0];
  assign bus.M2  = r_m[1];
  assign bus.M3  = r_m[2];
  assign bus.M4  = r_m[3];
  assign bus.M5  = r_m[4];
  assign bus.M6  = r_m[5];

endmodule

`default_nettype wire

// File: tb/tb_huffman_code_seq.sv
// ============================================================================
// Module      : tb_huffman_code_seq
// Description : Self-checking bench for huffman_code_seq. Known count sets
//               with hand-derived codes, random count sets against a
//               reference Huffman model, and hand-written sequences for a
//               strobe during MERGE, reset mid-sequence and back-to-back
//               runs. Outputs are packed as {M6..M1, HC6..HC1}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_huffman_code_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huffman_code_seq_if #(.CNT_W(8), .CODE_W(8)) bus ();

  huffman_code_seq #(.CNT_W(8), .CODE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [47:0] cnt;
    logic [95:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [95:0] last_exp;
  logic [47:0] t1_cnt, t2_cnt;
  logic [95:0] t1_exp;
  vec_t        tbl [3];

  function automatic logic [47:0] mk_cnt(input int c1, c2, c3, c4, c5, c6);
    return {8'(c6), 8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1)};
  endfunction

  function automatic logic [95:0] mk_out(input logic [47:0] hc, input logic [47:0] m);
    return {m, hc};
  endfunction

  function automatic logic [95:0] outs();
    return {bus.M6, bus.M5, bus.M4, bus.M3, bus.M2, bus.M1,
            bus.HC6, bus.HC5, bus.HC4, bus.HC3, bus.HC2, bus.HC1};
  endfunction

  // Reference: classic Huffman pairing over a list of live slots. Each symbol
  // remembers the slot that owns it; merging prepends one code bit.
  function automatic logic [95:0] model(input logic [47:0] c);
    int w[6];
    int owner[6];
    int code[6];
    int len[6];
    int alive[$];
    int a, b, keep, drop, di;
    logic [95:0] r;
    for (int k = 0; k < 6; k++) begin
      w[k] = int'(c[8*k +: 8]);
      owner[k] = k; code[k] = 0; len[k] = 0;
      alive.push_back(k);
    end
    repeat (5) begin
      a = -1;
      foreach (alive[i]) begin
        if (a < 0) a = alive[i];
        else if (w[alive[i]] < w[a] || (w[alive[i]] == w[a] && alive[i] > a)) a = alive[i];
      end
      b = -1;
      foreach (alive[i]) begin
        if (alive[i] != a) begin
          if (b < 0) b = alive[i];
          else if (w[alive[i]] < w[b] || (w[alive[i]] == w[b] && alive[i] > b)) b = alive[i];
        end
      end
      for (int s = 0; s < 6; s++) begin
        if (owner[s] == a) begin
          code[s] = code[s] + (1 << len[s]);
          len[s]  = len[s] + 1;
        end else if (owner[s] == b) begin
          len[s]  = len[s] + 1;
        end
      end
      keep = (a < b) ? a : b;
      drop = (a < b) ? b : a;
      w[keep] = w[a] + w[b];
      for (int s = 0; s < 6; s++)
        if (owner[s] == a || owner[s] == b) owner[s] = keep;
      di = 0;
      foreach (alive[i]) if (alive[i] == drop) di = i;
      alive.delete(di);
    end
    for (int k = 0; k < 6; k++) begin
      r[8*k +: 8]      = 8'(code[k]);
      r[48 + 8*k +: 8] = 8'((1 << len[k]) - 1);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cnt(input logic [47:0] c);
    bus.CNT1 = c[7:0];
    bus.CNT2 = c[15:8];
    bus.CNT3 = c[23:16];
    bus.CNT4 = c[31:24];
    bus.CNT5 = c[39:32];
    bus.CNT6 = c[47:40];
  endtask

  // Strobe counts, then watch 7 cycles: busy must be high for cycles 1..6,
  // code_valid only in cycle 7, and HC/M must hold the old result until then.
  // chained=1 drives the strobe at the current negedge (the code_valid cycle
  // of the previous run). inject>0 pulses t2_cnt during that MERGE cycle.
  task automatic run(input string name, input logic [47:0] c, input logic [95:0] exp,
                     input bit chained, input int inject);
    logic [6:0] bt, ct;
    if (!chained) begin
      @(negedge clk);
      check({name, " idle"}, {94'd0, bus.busy, bus.code_valid}, 96'd0);
    end
    drive_cnt(c);
    bus.CNT_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) bus.CNT_valid = 1'b0;
      if (inject != 0 && k == inject) begin
        drive_cnt(t2_cnt);
        bus.CNT_valid = 1'b1;
      end
      if (inject != 0 && k == inject + 1) bus.CNT_valid = 1'b0;
      bt[k-1] = bus.busy;
      ct[k-1] = bus.code_valid;
      if (k < 7) check({name, " hold"}, outs(), last_exp);
    end
    check({name, " busy_trace"}, {89'd0, bt}, {89'd0, 7'b0111111});
    check({name, " valid_trace"}, {89'd0, ct}, {89'd0, 7'b1000000});
    check({name, " codes"}, outs(), exp);
    last_exp = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] c;
    logic [95:0] e;
    bit          cv_seen;

    t1_cnt = mk_cnt(40, 20, 15, 10, 10, 5);
    t1_exp = mk_out(mk_cnt(8'h01, 8'h00, 8'h01, 8'h03, 8'h04, 8'h05),
                    mk_cnt(8'h01, 8'h07, 8'h07, 8'h07, 8'h0F, 8'h0F));
    t2_cnt = mk_cnt(100, 0, 0, 0, 0, 0);
    tbl[0] = '{cnt: t1_cnt, exp: t1_exp};
    tbl[1] = '{cnt: t2_cnt,
               exp: mk_out(mk_cnt(8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F),
                           mk_cnt(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F))};
    tbl[2] = '{cnt: mk_cnt(1, 1, 1, 1, 1, 1),
               exp: mk_out(mk_cnt(8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03),
                           mk_cnt(8'h03, 8'h03, 8'h07, 8'h07, 8'h07, 8'h07))};

    reset = 1'b0;
    bus.CNT_valid = 1'b0;
    drive_cnt(48'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("reset outs", outs(), 96'd0);
    check("reset flags", {94'd0, bus.busy, bus.code_valid}, 96'd0);
    last_exp = 96'd0;

    // Known count sets
    for (int i = 0; i < 3; i++) run($sformatf("table%0d", i), tbl[i].cnt, tbl[i].exp, 1'b0, 0);

    // Strobe during MERGE must be ignored
    run("ignore_busy", t1_cnt, t1_exp, 1'b0, 3);

    // Reset during MERGE step 3 aborts with no output
    @(negedge clk);
    drive_cnt(t1_cnt);
    bus.CNT_valid = 1'b1;
    @(negedge clk);
    bus.CNT_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset outs", outs(), 96'd0);
    check("midreset flags", {94'd0, bus.busy, bus.code_valid}, 96'd0);
    last_exp = 96'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cv_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.code_valid || bus.busy) cv_seen = 1'b1;
    end
    check("midreset no_pulse", {95'd0, cv_seen}, 96'd0);
    run("after_reset", t1_cnt, t1_exp, 1'b0, 0);

    // Back-to-back: second strobe in the code_valid cycle of the first
    run("b2b_first", t1_cnt, t1_exp, 1'b0, 0);
    run("b2b_second", t2_cnt, tbl[1].exp, 1'b1, 0);

    // Random count sets against the reference model
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 6; k++)
        c[8*k +: 8] = (it % 2 == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 85));
      e = model(c);
      run($sformatf("rand%0d", it), c, e, (it % 5 == 4), 0);
    end

    @(negedge clk);
    check("final idle", {94'd0, bus.busy, bus.code_valid}, 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
